// File: rtl/pa_iu_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : pa_iu_addr_seq
// Brief    : Sequential IU address generator. Issues per-beat LSU addresses
//            and then a one-cycle base-writeback result.
// Revision : 1.0 - initial release
// ============================================================================
module pa_iu_addr_seq #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BEATS  = 16,
   parameter int STRIDE     = 4,
   parameter int CNT_W      = $clog2(MAX_BEATS + 1)
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  idu_ag_req_vld,
   output logic                  ag_idu_req_rdy,
   input  logic [ADDR_WIDTH-1:0] idu_ag_base,
   input  logic [ADDR_WIDTH-1:0] idu_ag_imm,
   input  logic                  idu_ag_use_pc,
   input  logic [ADDR_WIDTH-1:0] idu_ag_pc,
   input  logic [CNT_W-1:0]      idu_ag_cnt,
   input  logic                  idu_ag_dec,
   output logic                  ag_lsu_addr_vld,
   input  logic                  lsu_ag_addr_rdy,
   output logic [ADDR_WIDTH-1:0] ag_lsu_addr,
   output logic [CNT_W-1:0]      ag_lsu_beat_idx,
   output logic                  ag_lsu_last,
   output logic                  ag_wb_vld,
   output logic [ADDR_WIDTH-1:0] ag_wb_data,
   output logic [ADDR_WIDTH-1:0] ag_bju_pc,
   input  logic                  rtu_ag_flush,
   output logic                  ag_busy
);

   localparam logic [ADDR_WIDTH-1:0] c_stride = ADDR_WIDTH'(STRIDE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_cur_addr;
   logic [CNT_W-1:0]        r_idx;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_dec;
   logic [ADDR_WIDTH-1:0]   r_wb_data;
   logic [ADDR_WIDTH-1:0]   w_start;
   logic [ADDR_WIDTH-1:0]   w_next_addr;
   logic                    w_issue;
   logic                    w_last;

   // PC-relative targets are halfword aligned, so PC bit 0 never contributes.
   assign w_start     = (idu_ag_use_pc ? (idu_ag_pc & ~ADDR_WIDTH'(1)) : idu_ag_base) + idu_ag_imm;
   assign w_next_addr = r_dec ? (r_cur_addr - c_stride) : (r_cur_addr + c_stride);
   assign w_issue     = (r_state == ST_ISSUE);
   assign w_last      = w_issue && (r_idx == (r_cnt - CNT_W'(1)));

   assign ag_idu_req_rdy  = (r_state == ST_IDLE);
   assign ag_busy         = (r_state != ST_IDLE);
   assign ag_lsu_addr_vld = w_issue;
   assign ag_lsu_addr     = r_cur_addr;
   assign ag_lsu_beat_idx = r_idx;
   assign ag_lsu_last     = w_last;
   assign ag_wb_vld       = (r_state == ST_WB);
   assign ag_wb_data      = r_wb_data;
   assign ag_bju_pc       = {r_wb_data[ADDR_WIDTH-1:1], 1'b0};

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (rtu_ag_flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (idu_ag_req_vld) begin
                  w_state_nxt = (idu_ag_cnt == '0) ? ST_WB : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (lsu_ag_addr_rdy && w_last) begin
                  w_state_nxt = ST_WB;
               end
            end
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_cur_addr <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_dec      <= 1'b0;
         r_wb_data  <= '0;
      end else if (!rtu_ag_flush) begin
         case (r_state)
            ST_IDLE: begin
               if (idu_ag_req_vld) begin
                  if (idu_ag_cnt == '0) begin
                     r_wb_data <= w_start;
                  end else begin
                     r_cur_addr <= w_start;
                     r_idx      <= '0;
                     r_cnt      <= idu_ag_cnt;
                     r_dec      <= idu_ag_dec;
                  end
               end
            end
            ST_ISSUE: begin
               if (lsu_ag_addr_rdy) begin
                  r_cur_addr <= w_next_addr;
                  r_idx      <= r_idx + CNT_W'(1);
                  // The post-increment address is the base-writeback value.
                  if (w_last) begin
                     r_wb_data <= w_next_addr;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pa_iu_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_iu_addr_seq
// Brief    : Self-checking bench for pa_iu_addr_seq with a list-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_iu_addr_seq;

   localparam int AW  = 32;
   localparam int MB  = 16;
   localparam int STR = 4;
   localparam int CW  = $clog2(MB + 1);

   logic          clk = 1'b0;
   logic          cpurst;
   logic          req_vld;
   logic          req_rdy;
   logic [AW-1:0] base, imm, pc;
   logic          use_pc;
   logic [CW-1:0] cnt;
   logic          dec;
   logic          addr_vld;
   logic          addr_rdy;
   logic [AW-1:0] addr;
   logic [CW-1:0] beat_idx;
   logic          last;
   logic          wb_vld;
   logic [AW-1:0] wb_data;
   logic [AW-1:0] bju_pc;
   logic          flush;
   logic          busy;

   int tests = 0;
   int fails = 0;

   pa_iu_addr_seq #(.ADDR_WIDTH(AW), .MAX_BEATS(MB), .STRIDE(STR)) dut (
      .forever_cpuclk  (clk),
      .cpurst          (cpurst),
      .idu_ag_req_vld  (req_vld),
      .ag_idu_req_rdy  (req_rdy),
      .idu_ag_base     (base),
      .idu_ag_imm      (imm),
      .idu_ag_use_pc   (use_pc),
      .idu_ag_pc       (pc),
      .idu_ag_cnt      (cnt),
      .idu_ag_dec      (dec),
      .ag_lsu_addr_vld (addr_vld),
      .lsu_ag_addr_rdy (addr_rdy),
      .ag_lsu_addr     (addr),
      .ag_lsu_beat_idx (beat_idx),
      .ag_lsu_last     (last),
      .ag_wb_vld       (wb_vld),
      .ag_wb_data      (wb_data),
      .ag_bju_pc       (bju_pc),
      .rtu_ag_flush    (flush),
      .ag_busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (req_vld) assert (cnt <= CW'(MB));
   end

   task automatic test_reset();
      cpurst = 1'b1;
      repeat (2) @(negedge clk);
      cpurst = 1'b0;
      tests++;
      if ({req_rdy, addr_vld, wb_vld, busy, last} !== 5'b10000 || addr !== '0 ||
          beat_idx !== '0 || wb_data !== '0 || bju_pc !== '0)
      begin
         fails++;
         $display("FAIL reset: rdy/vld/wb/busy/last=%b addr=%h idx=%0d wb=%h bju=%h required 10000 and zeros",
                  {req_rdy, addr_vld, wb_vld, busy, last}, addr, beat_idx, wb_data, bju_pc);
      end
   endtask

   // Generic request: model builds the expected beat list from S +/- i*STRIDE.
   task automatic test_burst(input string nm, input logic u_pc, input logic [AW-1:0] p,
                             input logic [AW-1:0] b, input logic [AW-1:0] im,
                             input int n, input logic d, input int rdy_pct,
                             input int hold_beat, input int hold_cycles);
      logic [AW-1:0] s;
      logic [AW-1:0] exp_addr [$];
      logic [AW-1:0] exp_wb;
      int beat, cycles, held;
      logic r;
      s = (u_pc ? {p[AW-1:1], 1'b0} : b) + im;
      exp_addr.delete();
      for (int i = 0; i < n; i++)
         exp_addr.push_back(d ? s - AW'(i * STR) : s + AW'(i * STR));
      exp_wb = d ? s - AW'(n * STR) : s + AW'(n * STR);

      @(negedge clk);
      tests++;
      if (req_rdy !== 1'b1) begin
         fails++;
         $display("FAIL %s req_rdy: got %b required 1", nm, req_rdy);
      end
      use_pc = u_pc; pc = p; base = b; imm = im; cnt = CW'(n); dec = d; req_vld = 1'b1;
      @(negedge clk);
      req_vld = 1'b0;
      beat = 0; cycles = 0; held = 0;
      while (beat < n && cycles < 400) begin
         tests++;
         if ({addr_vld, wb_vld} !== 2'b10 || addr !== exp_addr[beat] ||
             beat_idx !== CW'(beat) || last !== (beat == n - 1)) begin
            fails++;
            $display("FAIL %s beat%0d: vld=%b wb=%b addr=%h idx=%0d last=%b required vld=1 wb=0 addr=%h idx=%0d last=%b",
                     nm, beat, addr_vld, wb_vld, addr, beat_idx, last, exp_addr[beat], beat, (beat == n - 1));
         end
         if (beat == hold_beat && held < hold_cycles) begin
            r = 1'b0;
            held++;
         end else begin
            r = ($urandom_range(99, 0) < rdy_pct);
         end
         addr_rdy = r;
         @(negedge clk);
         if (r) beat++;
         cycles++;
      end
      addr_rdy = 1'b0;
      if (cycles >= 400) begin
         tests++; fails++;
         $display("FAIL %s timeout: beats sent %0d required %0d", nm, beat, n);
      end
      tests++;
      if (wb_vld !== 1'b1 || addr_vld !== 1'b0 || wb_data !== exp_wb ||
          bju_pc !== {exp_wb[AW-1:1], 1'b0}) begin
         fails++;
         $display("FAIL %s wb: vld=%b lsu_vld=%b data=%h bju=%h required 1 0 %h %h",
                  nm, wb_vld, addr_vld, wb_data, bju_pc, exp_wb, {exp_wb[AW-1:1], 1'b0});
      end
      @(negedge clk);
      tests++;
      if (wb_vld !== 1'b0 || req_rdy !== 1'b1 || busy !== 1'b0 || wb_data !== exp_wb) begin
         fails++;
         $display("FAIL %s post_wb: wb=%b rdy=%b busy=%b data=%h required 0 1 0 %h",
                  nm, wb_vld, req_rdy, busy, wb_data, exp_wb);
      end
   endtask

   task automatic test_flush();
      int cyc;
      @(negedge clk);
      use_pc = 1'b0; base = 32'h4000_0000; imm = 32'h0; cnt = CW'(8); dec = 1'b0; req_vld = 1'b1;
      @(negedge clk);
      req_vld = 1'b0;
      addr_rdy = 1'b1;
      cyc = 0;
      while (!(addr_vld && beat_idx == CW'(2)) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      tests++;
      if (addr !== 32'h4000_0008) begin
         fails++;
         $display("FAIL flush beat2 addr: got %h required 40000008", addr);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      addr_rdy = 1'b0;
      tests++;
      if ({addr_vld, wb_vld, busy, req_rdy} !== 4'b0001) begin
         fails++;
         $display("FAIL flush idle: vld/wb/busy/rdy=%b required 0001", {addr_vld, wb_vld, busy, req_rdy});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (wb_vld !== 1'b0 || addr_vld !== 1'b0) begin
            fails++;
            $display("FAIL flush no_wb: wb=%b vld=%b required 0 0", wb_vld, addr_vld);
         end
      end
   endtask

   task automatic test_flush_req();
      @(negedge clk);
      use_pc = 1'b0; base = 32'h10; imm = 32'h0; cnt = CW'(2); dec = 1'b0;
      req_vld = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_vld = 1'b0; flush = 1'b0;
      tests++;
      if ({addr_vld, wb_vld, busy} !== 3'b000) begin
         fails++;
         $display("FAIL flush_req dropped: vld/wb/busy=%b required 000", {addr_vld, wb_vld, busy});
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      use_pc = 1'b0; base = 32'h5000_0000; imm = 32'h4; cnt = CW'(10); dec = 1'b0; req_vld = 1'b1;
      @(negedge clk);
      req_vld = 1'b0;
      addr_rdy = 1'b1;
      cyc = 0;
      while (!(addr_vld && beat_idx == CW'(5)) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      cpurst = 1'b1;
      @(negedge clk);
      cpurst = 1'b0;
      addr_rdy = 1'b0;
      tests++;
      if ({addr_vld, wb_vld, busy, req_rdy} !== 4'b0001 || addr !== '0 || wb_data !== '0) begin
         fails++;
         $display("FAIL reset_mid: vld/wb/busy/rdy=%b addr=%h wb=%h required 0001 0 0",
                  {addr_vld, wb_vld, busy, req_rdy}, addr, wb_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (wb_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid no_wb: got %b required 0", wb_vld);
         end
      end
   endtask

   // Request held high continuously: accept, 2 beats, WB, IDLE, accept again.
   task automatic test_back_to_back();
      logic [1:0] exp_vld [8] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
      @(negedge clk);
      use_pc = 1'b0; base = 32'h0000_0100; imm = 32'h0; cnt = CW'(2); dec = 1'b0;
      addr_rdy = 1'b1; req_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests++;
         if ({addr_vld, wb_vld} !== exp_vld[i]) begin
            fails++;
            $display("FAIL b2b cycle%0d: vld/wb=%b required %b", i + 1, {addr_vld, wb_vld}, exp_vld[i]);
         end
      end
      req_vld = 1'b0;
      addr_rdy = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         test_burst("rand", 1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(MB, 0)), 1'($urandom), int'($urandom_range(100, 40)), -1, 0);
      end
   endtask

   initial begin
      cpurst = 1'b0; req_vld = 1'b0; base = '0; imm = '0; pc = '0; use_pc = 1'b0;
      cnt = '0; dec = 1'b0; addr_rdy = 1'b0; flush = 1'b0;
      test_reset();
      test_burst("pc_target", 1'b1, 32'h0000_1003, 32'hDEAD_BEEF, 32'h0000_0100, 0, 1'b0, 100, -1, 0);
      test_burst("ascend", 1'b0, 32'h0, 32'h2000_0000, 32'h10, 4, 1'b0, 100, -1, 0);
      test_burst("descend_bp", 1'b0, 32'h0, 32'h8000_0040, 32'hFFFF_FFFC, 3, 1'b1, 100, 1, 2);
      test_burst("wrap", 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0, 4, 1'b0, 100, -1, 0);
      test_flush();
      test_flush_req();
      test_reset_mid();
      test_burst("max_beats", 1'b0, 32'h0, 32'h0000_1000, 32'h0, MB, 1'b0, 100, -1, 0);
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
